tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Sequencer for the blocked matrix multiplier. It walks the output matrix tile by tile, with k innermost, and issues one tile operation at a time to the tile compute engine. Each issued tile carries its base indices, its extents, and accumulator clear/writeback flags. It sits between the top-level start/done control and the tile engine. It replaces the free-running internal loop control of the multiplier top.

## Interface
Parameters:
- FIRST_MATRIX_ROW_SIZE, 18, rows of A (M)
- MATRIX_SIZE, 60, shared dimension (K)
- SECOND_MATRIX_COL_SIZE, 21, columns of B (N)
- FIRST_BLOCK_ROW_SIZE, 9, tile rows (TM)
- BLOCK_SIZE, 3, tile depth (TK)
- SECOND_BLOCK_COL_SIZE, 3, tile columns (TN)
- Derived: MT=ceil(M/TM), NT=ceil(N/TN), KT=ceil(K/TK), TOTAL=MT*NT*KT (defaults 2, 7, 20, 280)

Ports:
- clock  in  1  system clock
- reset  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  begin a full multiply; sampled only in IDLE or DONE
- busy  out  1  high from accepted start until the final tile_done
- done  out  1  level; high in DONE; cleared when the next start is accepted
- tile_valid  out  1  tile descriptor valid
- tile_ready  in  1  engine accepts the descriptor
- tile_row_base  out  $clog2(M)  first A row of the tile
- tile_col_base  out  $clog2(N)  first B column of the tile
- tile_k_base  out  $clog2(K)  first k index of the tile
- tile_rows  out  $clog2(TM+1)  valid rows, min(TM, M-row_base)
- tile_cols  out  $clog2(TN+1)  valid columns, min(TN, N-col_base)
- tile_k  out  $clog2(TK+1)  valid depth, min(TK, K-k_base)
- tile_acc_clear  out  1  first k-tile of this output tile; engine zeroes the accumulator
- tile_last_k  out  1  last k-tile; engine writes the accumulator to the output buffer
- tile_done  in  1  one-cycle pulse; engine finished the accepted tile
- tile_count  out  $clog2(TOTAL+1)  completed tiles in the current run

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE/DONE with start=1:
  - Clear the indices (mi, ni, ki) and tile_count.
  - Set busy=1 and done=0, then go to ISSUE.
- ISSUE:
  - tile_valid=1.
  - All descriptor outputs are registered and must hold stable until tile_valid and tile_ready are both 1.
  - On that handshake go to WAIT.
- WAIT:
  - tile_valid=0.
  - On tile_done: tile_count+1, then advance the indices.
  - ki increments first. On ki wrap (ki==KT-1 -> 0), ni increments. On ni wrap, mi increments.
  - If (mi, ni, ki) was (MT-1, NT-1, KT-1): go to DONE with busy=0 and done=1. Otherwise go back to ISSUE.
- Bases are computed as mi*TM, ni*TN, ki*TK. Use incremental adders, not multipliers.
- tile_acc_clear = (ki==0). tile_last_k = (ki==KT-1). When KT==1, both are 1.
- Partial last tiles (non-divisible sizes) take their extents from the min() rule. Full tiles report exactly TM, TN, TK.
- Ignored inputs:
  - start in ISSUE or WAIT.
  - tile_done in IDLE, ISSUE or DONE.
  - tile_ready outside ISSUE.
- Exactly one tile is outstanding at any time.
- Reset asserted mid-run: all state returns immediately to reset values. A tile in flight in the engine is abandoned; the engine is reset by the same signal.

## Timing
- Reset values:
  - State IDLE; busy=0, done=0, tile_valid=0, tile_acc_clear=0, tile_last_k=0, tile_count=0.
  - All bases and extents 0.
- start sampled high at edge t: busy and tile_valid are high after edge t, so the first descriptor is presented in cycle t+1.
- Handshake at edge h: tile_valid is low after h.
- tile_done sampled at edge d:
  - The next descriptor (tile_valid=1) appears after d.
  - Or, for the last tile, done=1 and busy=0 after d.
- Scheduler overhead: one cycle per tile, between tile_done and the next tile_valid, plus the engine's ready latency.
- tile_done coincident with start: tile_done is ignored, because it cannot occur in IDLE/DONE.
- tile_done in the same cycle as the handshake: ignored; the state is still ISSUE.

## Test plan
- Default parameters, engine with tile_ready=1 and tile_done 4 cycles after accept:
  - tile_count reaches 280.
  - The first descriptor is (0,0,0), rows=9, cols=3, k=3, clear=1.
  - The 20th descriptor is (0,0,57) with last_k=1.
  - The 21st descriptor is (0,3,0) with clear=1.
  - done rises after the 280th tile_done.
- M=10, K=10, N=7, TM=4, TK=3, TN=3:
  - Extents seen: rows 4,4,2; cols 3,3,1; k 3,3,3,1.
  - TOTAL=36; the last descriptor is (8,6,9) with rows=2, cols=1, k=1.
- Backpressure: hold tile_ready=0 for 5 cycles while in ISSUE.
  - The descriptor stays stable and tile_valid stays high.
  - Pulsing tile_done during this window has no effect (tile_count unchanged).
- start pulsed during WAIT: no restart, and tile_count continues monotonically. start in DONE begins a new run: done=0 next cycle, tile_count=0.
- Reset driven low asynchronously mid-run (tile_count=57): outputs return to reset values immediately, before the next clock edge. After release, a new start gives the first descriptor (0,0,0).
- K=TK=3 (KT=1): every descriptor has tile_acc_clear=1 and tile_last_k=1.

Source files
------------

// File: rtl/tile_scheduler.sv
// Tile sequencer for the blocked matrix multiplier: walks output tiles (k innermost)
// and issues one registered descriptor at a time to the tile engine via valid/ready.
module tile_scheduler #(
   parameter  int unsigned FIRST_MATRIX_ROW_SIZE  = 18,
   parameter  int unsigned MATRIX_SIZE            = 60,
   parameter  int unsigned SECOND_MATRIX_COL_SIZE = 21,
   parameter  int unsigned FIRST_BLOCK_ROW_SIZE   = 9,
   parameter  int unsigned BLOCK_SIZE             = 3,
   parameter  int unsigned SECOND_BLOCK_COL_SIZE  = 3,
   localparam int unsigned MT    = (FIRST_MATRIX_ROW_SIZE + FIRST_BLOCK_ROW_SIZE - 1) / FIRST_BLOCK_ROW_SIZE,
   localparam int unsigned NT    = (SECOND_MATRIX_COL_SIZE + SECOND_BLOCK_COL_SIZE - 1) / SECOND_BLOCK_COL_SIZE,
   localparam int unsigned KT    = (MATRIX_SIZE + BLOCK_SIZE - 1) / BLOCK_SIZE,
   localparam int unsigned TOTAL = MT * NT * KT,
   localparam int unsigned RW    = (FIRST_MATRIX_ROW_SIZE > 1) ? $clog2(FIRST_MATRIX_ROW_SIZE) : 1,
   localparam int unsigned CBW   = (SECOND_MATRIX_COL_SIZE > 1) ? $clog2(SECOND_MATRIX_COL_SIZE) : 1,
   localparam int unsigned KW    = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
   localparam int unsigned ERW   = $clog2(FIRST_BLOCK_ROW_SIZE + 1),
   localparam int unsigned ECW   = $clog2(SECOND_BLOCK_COL_SIZE + 1),
   localparam int unsigned EKW   = $clog2(BLOCK_SIZE + 1),
   localparam int unsigned CW    = $clog2(TOTAL + 1)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic           tile_valid,
   input  logic           tile_ready,
   output logic [RW-1:0]  tile_row_base,
   output logic [CBW-1:0] tile_col_base,
   output logic [KW-1:0]  tile_k_base,
   output logic [ERW-1:0] tile_rows,
   output logic [ECW-1:0] tile_cols,
   output logic [EKW-1:0] tile_k,
   output logic           tile_acc_clear,
   output logic           tile_last_k,
   input  logic           tile_done,
   output logic [CW-1:0]  tile_count
);

   localparam int unsigned MIW = (MT > 1) ? $clog2(MT) : 1;
   localparam int unsigned NIW = (NT > 1) ? $clog2(NT) : 1;
   localparam int unsigned KIW = (KT > 1) ? $clog2(KT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t         state_q;
   logic [MIW-1:0] mi_q, mi_d;
   logic [NIW-1:0] ni_q, ni_d;
   logic [KIW-1:0] ki_q, ki_d;
   logic [RW-1:0]  rb_q, rb_d;
   logic [CBW-1:0] cb_q, cb_d;
   logic [KW-1:0]  kb_q, kb_d;
   logic [ERW-1:0] rows_q, rows_d;
   logic [ECW-1:0] cols_q, cols_d;
   logic [EKW-1:0] kext_q, kext_d;
   logic           clr_q, clr_d, lastk_q, lastk_d;
   logic           busy_q, done_q, valid_q;
   logic [CW-1:0]  cnt_q;
   logic           k_wrap, n_wrap, final_tile;

   // Remaining span clipped to the tile size; a wrapped base on the final tile is never issued.
   function automatic int unsigned extent(int unsigned lim, int unsigned base, int unsigned t);
      return (lim - base < t) ? lim - base : t;
   endfunction

   always_comb begin
      k_wrap     = (ki_q == KIW'(KT - 1));
      n_wrap     = (ni_q == NIW'(NT - 1));
      final_tile = k_wrap && n_wrap && (mi_q == MIW'(MT - 1));
      ki_d = k_wrap ? '0 : ki_q + 1'b1;
      kb_d = k_wrap ? '0 : kb_q + KW'(BLOCK_SIZE);
      ni_d = ni_q;
      cb_d = cb_q;
      mi_d = mi_q;
      rb_d = rb_q;
      if (k_wrap) begin
         ni_d = n_wrap ? '0 : ni_q + 1'b1;
         cb_d = n_wrap ? '0 : cb_q + CBW'(SECOND_BLOCK_COL_SIZE);
         if (n_wrap) begin
            mi_d = mi_q + 1'b1;
            rb_d = rb_q + RW'(FIRST_BLOCK_ROW_SIZE);
         end
      end
      rows_d  = ERW'(extent(FIRST_MATRIX_ROW_SIZE, 32'(rb_d), FIRST_BLOCK_ROW_SIZE));
      cols_d  = ECW'(extent(SECOND_MATRIX_COL_SIZE, 32'(cb_d), SECOND_BLOCK_COL_SIZE));
      kext_d  = EKW'(extent(MATRIX_SIZE, 32'(kb_d), BLOCK_SIZE));
      clr_d   = (ki_d == '0);
      lastk_d = (ki_d == KIW'(KT - 1));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         mi_q    <= '0;  ni_q   <= '0;  ki_q   <= '0;
         rb_q    <= '0;  cb_q   <= '0;  kb_q   <= '0;
         rows_q  <= '0;  cols_q <= '0;  kext_q <= '0;
         clr_q   <= 1'b0; lastk_q <= 1'b0;
         busy_q  <= 1'b0; done_q  <= 1'b0; valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  mi_q    <= '0;  ni_q <= '0;  ki_q <= '0;
                  rb_q    <= '0;  cb_q <= '0;  kb_q <= '0;
                  rows_q  <= ERW'(extent(FIRST_MATRIX_ROW_SIZE, 0, FIRST_BLOCK_ROW_SIZE));
                  cols_q  <= ECW'(extent(SECOND_MATRIX_COL_SIZE, 0, SECOND_BLOCK_COL_SIZE));
                  kext_q  <= EKW'(extent(MATRIX_SIZE, 0, BLOCK_SIZE));
                  clr_q   <= 1'b1;
                  lastk_q <= (KT == 1);
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (tile_ready) begin
                  valid_q <= 1'b0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (tile_done) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (final_tile) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     mi_q    <= mi_d;   ni_q   <= ni_d;   ki_q   <= ki_d;
                     rb_q    <= rb_d;   cb_q   <= cb_d;   kb_q   <= kb_d;
                     rows_q  <= rows_d; cols_q <= cols_d; kext_q <= kext_d;
                     clr_q   <= clr_d;  lastk_q <= lastk_d;
                     valid_q <= 1'b1;
                     state_q <= S_ISSUE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign tile_valid     = valid_q;
   assign tile_row_base  = rb_q;
   assign tile_col_base  = cb_q;
   assign tile_k_base    = kb_q;
   assign tile_rows      = rows_q;
   assign tile_cols      = cols_q;
   assign tile_k         = kext_q;
   assign tile_acc_clear = clr_q;
   assign tile_last_k    = lastk_q;
   assign tile_count     = cnt_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Bench for tile_scheduler: three parameterisations driven by a randomized engine and
// checked against a nested-loop model of the tile walk.
module tb_tile_scheduler;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst_n, start, ready, tdone;
   int   sel;
   int   total = 0;
   int   bad   = 0;

   // Instance A: defaults (18x60x21, tiles 9x3x3)
   logic                    a_busy, a_done, a_valid, a_clr, a_last;
   logic [$clog2(18)-1:0]   a_rb;
   logic [$clog2(21)-1:0]   a_cb;
   logic [$clog2(60)-1:0]   a_kb;
   logic [$clog2(10)-1:0]   a_rows;
   logic [$clog2(4)-1:0]    a_cols, a_k;
   logic [$clog2(281)-1:0]  a_cnt;
   // Instance B: 10x10x7, tiles 4x3x3
   logic                    b_busy, b_done, b_valid, b_clr, b_last;
   logic [$clog2(10)-1:0]   b_rb;
   logic [$clog2(7)-1:0]    b_cb;
   logic [$clog2(10)-1:0]   b_kb;
   logic [$clog2(5)-1:0]    b_rows;
   logic [$clog2(4)-1:0]    b_cols, b_k;
   logic [$clog2(37)-1:0]   b_cnt;
   // Instance C: 4x3x4, tiles 2x3x2 (single k-tile)
   logic                    c_busy, c_done, c_valid, c_clr, c_last;
   logic [$clog2(4)-1:0]    c_rb, c_cb, c_kb;
   logic [$clog2(3)-1:0]    c_rows, c_cols;
   logic [$clog2(4)-1:0]    c_k;
   logic [$clog2(5)-1:0]    c_cnt;

   tile_scheduler u_a (
      .clock(clock), .reset(rst_n), .start(start && sel == 0),
      .busy(a_busy), .done(a_done), .tile_valid(a_valid), .tile_ready(ready && sel == 0),
      .tile_row_base(a_rb), .tile_col_base(a_cb), .tile_k_base(a_kb),
      .tile_rows(a_rows), .tile_cols(a_cols), .tile_k(a_k),
      .tile_acc_clear(a_clr), .tile_last_k(a_last), .tile_done(tdone && sel == 0),
      .tile_count(a_cnt));

   tile_scheduler #(
      .FIRST_MATRIX_ROW_SIZE(10), .MATRIX_SIZE(10), .SECOND_MATRIX_COL_SIZE(7),
      .FIRST_BLOCK_ROW_SIZE(4), .BLOCK_SIZE(3), .SECOND_BLOCK_COL_SIZE(3)
   ) u_b (
      .clock(clock), .reset(rst_n), .start(start && sel == 1),
      .busy(b_busy), .done(b_done), .tile_valid(b_valid), .tile_ready(ready && sel == 1),
      .tile_row_base(b_rb), .tile_col_base(b_cb), .tile_k_base(b_kb),
      .tile_rows(b_rows), .tile_cols(b_cols), .tile_k(b_k),
      .tile_acc_clear(b_clr), .tile_last_k(b_last), .tile_done(tdone && sel == 1),
      .tile_count(b_cnt));

   tile_scheduler #(
      .FIRST_MATRIX_ROW_SIZE(4), .MATRIX_SIZE(3), .SECOND_MATRIX_COL_SIZE(4),
      .FIRST_BLOCK_ROW_SIZE(2), .BLOCK_SIZE(3), .SECOND_BLOCK_COL_SIZE(2)
   ) u_c (
      .clock(clock), .reset(rst_n), .start(start && sel == 2),
      .busy(c_busy), .done(c_done), .tile_valid(c_valid), .tile_ready(ready && sel == 2),
      .tile_row_base(c_rb), .tile_col_base(c_cb), .tile_k_base(c_kb),
      .tile_rows(c_rows), .tile_cols(c_cols), .tile_k(c_k),
      .tile_acc_clear(c_clr), .tile_last_k(c_last), .tile_done(tdone && sel == 2),
      .tile_count(c_cnt));

   int   o_rb, o_cb, o_kb, o_rows, o_cols, o_k, o_cnt;
   logic o_busy, o_done, o_valid, o_clr, o_last;

   always_comb begin
      o_busy = 1'b0; o_done = 1'b0; o_valid = 1'b0; o_clr = 1'b0; o_last = 1'b0;
      o_rb = 0; o_cb = 0; o_kb = 0; o_rows = 0; o_cols = 0; o_k = 0; o_cnt = 0;
      case (sel)
         0: begin
            o_busy = a_busy; o_done = a_done; o_valid = a_valid; o_clr = a_clr; o_last = a_last;
            o_rb = int'(a_rb); o_cb = int'(a_cb); o_kb = int'(a_kb);
            o_rows = int'(a_rows); o_cols = int'(a_cols); o_k = int'(a_k); o_cnt = int'(a_cnt);
         end
         1: begin
            o_busy = b_busy; o_done = b_done; o_valid = b_valid; o_clr = b_clr; o_last = b_last;
            o_rb = int'(b_rb); o_cb = int'(b_cb); o_kb = int'(b_kb);
            o_rows = int'(b_rows); o_cols = int'(b_cols); o_k = int'(b_k); o_cnt = int'(b_cnt);
         end
         default: begin
            o_busy = c_busy; o_done = c_done; o_valid = c_valid; o_clr = c_clr; o_last = c_last;
            o_rb = int'(c_rb); o_cb = int'(c_cb); o_kb = int'(c_kb);
            o_rows = int'(c_rows); o_cols = int'(c_cols); o_k = int'(c_k); o_cnt = int'(c_cnt);
         end
      endcase
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk_desc(input string tag, input int rb, input int cb, input int kb,
                           input int rows, input int cols, input int k, input int clr, input int last);
      chk({tag, "_row_base"}, o_rb, rb);
      chk({tag, "_col_base"}, o_cb, cb);
      chk({tag, "_k_base"},   o_kb, kb);
      chk({tag, "_rows"},     o_rows, rows);
      chk({tag, "_cols"},     o_cols, cols);
      chk({tag, "_k"},        o_k, k);
      chk({tag, "_clear"},    int'(o_clr), clr);
      chk({tag, "_last_k"},   int'(o_last), last);
   endtask

   task automatic chk_reset_vals();
      chk("rst_busy", int'(o_busy), 0);
      chk("rst_done", int'(o_done), 0);
      chk("rst_valid", int'(o_valid), 0);
      chk("rst_count", o_cnt, 0);
      chk_desc("rst", 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Full run walked in spec order; bp_at injects backpressure, a spurious start and
   // a handshake-coincident tile_done on that tile; abort_at resets after that many tiles.
   task automatic run(input int s, input int M, input int K, input int N,
                      input int TM, input int TK, input int TN,
                      input bit rnd, input int bp_at, input int abort_at);
      int idx, n, exp_total, rlat, dlat;
      bit last;
      sel = s;
      exp_total = ((M + TM - 1) / TM) * ((N + TN - 1) / TN) * ((K + TK - 1) / TK);
      start = 1'b1; tdone = 1'b1;
      tick();
      start = 1'b0; tdone = 1'b0;
      chk("start_busy", int'(o_busy), 1);
      chk("start_done", int'(o_done), 0);
      chk("start_valid", int'(o_valid), 1);
      chk("start_count", o_cnt, 0);
      idx = 0;
      for (int mr = 0; mr < M; mr += TM)
         for (int nc = 0; nc < N; nc += TN)
            for (int kk = 0; kk < K; kk += TK) begin
               n = 0;
               while (!o_valid && n < 40) begin tick(); n++; end
               chk("valid_wait", int'(o_valid), 1);
               chk_desc("desc", mr, nc, kk, min2(TM, M - mr), min2(TN, N - nc), min2(TK, K - kk),
                        int'(kk == 0), int'(kk + TK >= K));
               rlat = rnd ? int'($urandom_range(0, 2)) : 0;
               if (idx == bp_at) rlat = 5;
               ready = 1'b0;
               for (int i = 0; i < rlat; i++) begin
                  tdone = (idx == bp_at && i == 2);
                  tick();
                  tdone = 1'b0;
                  if (idx == bp_at) begin
                     chk("bp_valid", int'(o_valid), 1);
                     chk_desc("bp", mr, nc, kk, min2(TM, M - mr), min2(TN, N - nc), min2(TK, K - kk),
                              int'(kk == 0), int'(kk + TK >= K));
                     chk("bp_count", o_cnt, idx);
                  end
               end
               ready = 1'b1;
               tdone = (idx == bp_at);
               tick();
               ready = 1'b0; tdone = 1'b0;
               chk("hs_valid", int'(o_valid), 0);
               chk("hs_count", o_cnt, idx);
               dlat = rnd ? int'($urandom_range(0, 4)) : 3;
               for (int i = 0; i < dlat; i++) begin
                  start = (idx == bp_at && i == 0);
                  tick();
                  start = 1'b0;
               end
               tdone = 1'b1;
               tick();
               tdone = 1'b0;
               idx++;
               chk("count", o_cnt, idx);
               if (idx == abort_at) begin
                  #2 rst_n = 1'b0;
                  #1 chk_reset_vals();
                  tick();
                  rst_n = 1'b1;
                  tick();
                  return;
               end
               last = (mr + TM >= M) && (nc + TN >= N) && (kk + TK >= K);
               if (last) begin
                  chk("end_done", int'(o_done), 1);
                  chk("end_busy", int'(o_busy), 0);
                  chk("end_valid", int'(o_valid), 0);
               end else begin
                  chk("next_valid", int'(o_valid), 1);
                  chk("next_busy", int'(o_busy), 1);
               end
            end
      chk("final_count", o_cnt, exp_total);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ready = 1'b0; tdone = 1'b0; sel = 0;
      tick();
      tick();
      chk_reset_vals();
      rst_n = 1'b1;
      tick();
      chk_reset_vals();

      run(0, 18, 60, 21, 9, 3, 3, 1'b0, 5, -1);
      tdone = 1'b1;
      tick();
      tdone = 1'b0;
      chk("done_hold", int'(o_done), 1);
      chk("done_ignore_count", o_cnt, 280);

      run(0, 18, 60, 21, 9, 3, 3, 1'b1, -1, 57);
      run(0, 18, 60, 21, 9, 3, 3, 1'b1, 30, -1);
      run(1, 10, 10, 7, 4, 3, 3, 1'b1, 3, -1);
      run(2, 4, 3, 4, 2, 3, 2, 1'b1, 1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
